// File: rtl/puf_pkg.sv
// Shared types and constants for the RO-PUF measurement controller.
package puf_pkg;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned WIN_W_DEF  = 16;
  localparam int unsigned SETTLE_CYC = 2;
  localparam int unsigned DRAIN_CYC  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_DRAIN,
    ST_DONE
  } meas_state_e;

endpackage

// File: rtl/puf_edge_cnt.sv
// One ring channel: 2-FF synchronizer, rising-edge detect and saturating edge counter.
module puf_edge_cnt
  import puf_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ro,
  input  logic             i_clr,
  input  logic             i_cnt_en,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]       sync_q;
  logic             edge_c;
  logic [CNT_W-1:0] cnt_q;

  // sync_q[1] is the synchronized ring level; sync_q[2] is its previous value
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], i_ro};
    end
  end

  assign edge_c = sync_q[1] & ~sync_q[2];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_cnt_en && edge_c && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/puf_ro_meas.sv
// RO-pair measurement controller: runs both rings for a window, compares edge counts.
// Optional stability flag (o_unstable, MARGIN) built when PUF_RO_MEAS_MARGIN_EN is defined.
module puf_ro_meas
  import puf_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned WIN_W  = WIN_W_DEF,
  parameter int unsigned MARGIN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIN_W-1:0] i_win,
  input  logic             i_ro_a,
  input  logic             i_ro_b,
  output logic             o_ro_en,
  output logic             o_busy,
  output logic             o_valid,
  output logic             o_bit,
  output logic             o_tie,
  output logic [CNT_W-1:0] o_cnt_a,
  output logic [CNT_W-1:0] o_cnt_b
`ifdef PUF_RO_MEAS_MARGIN_EN
  ,
  output logic             o_unstable
`endif
);

  meas_state_e      state_q;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] cyc_q;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;
  logic             clr_c;
  logic             cnt_en_c;
  logic             result_ld_c;

  assign clr_c       = (state_q == ST_SETTLE);
  assign cnt_en_c    = (state_q == ST_COUNT);
  assign result_ld_c = (state_q == ST_DRAIN) && (cyc_q == '0);

  puf_edge_cnt #(.CNT_W(CNT_W)) u_cnt_a (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_ro     (i_ro_a),
    .i_clr    (clr_c),
    .i_cnt_en (cnt_en_c),
    .o_cnt    (cnt_a)
  );

  puf_edge_cnt #(.CNT_W(CNT_W)) u_cnt_b (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_ro     (i_ro_b),
    .i_clr    (clr_c),
    .i_cnt_en (cnt_en_c),
    .o_cnt    (cnt_b)
  );

  // cyc_q counts down the cycles left in SETTLE, COUNT and DRAIN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      cyc_q   <= '0;
      o_ro_en <= 1'b0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_bit   <= 1'b0;
      o_tie   <= 1'b0;
      o_cnt_a <= '0;
      o_cnt_b <= '0;
    end else begin
      o_valid <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            win_q   <= (i_win == '0) ? WIN_W'(1) : i_win;
            cyc_q   <= WIN_W'(SETTLE_CYC - 1);
            state_q <= ST_SETTLE;
            o_ro_en <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cyc_q == '0) begin
            cyc_q   <= win_q - WIN_W'(1);
            state_q <= ST_COUNT;
          end else begin
            cyc_q <= cyc_q - WIN_W'(1);
          end
        end
        ST_COUNT: begin
          if (cyc_q == '0) begin
            cyc_q   <= WIN_W'(DRAIN_CYC - 1);
            state_q <= ST_DRAIN;
            o_ro_en <= 1'b0;
          end else begin
            cyc_q <= cyc_q - WIN_W'(1);
          end
        end
        ST_DRAIN: begin
          if (result_ld_c) begin
            state_q <= ST_DONE;
            o_busy  <= 1'b0;
            o_valid <= 1'b1;
            o_cnt_a <= cnt_a;
            o_cnt_b <= cnt_b;
            o_bit   <= (cnt_a > cnt_b);
            o_tie   <= (cnt_a == cnt_b);
          end else begin
            cyc_q <= cyc_q - WIN_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          o_ro_en <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PUF_RO_MEAS_MARGIN_EN
  logic [CNT_W-1:0] diff_c;
  logic             unstable_c;

  // Distance taken on the saturated counts
  always_comb begin
    diff_c     = (cnt_a > cnt_b) ? (cnt_a - cnt_b) : (cnt_b - cnt_a);
    unstable_c = (32'(diff_c) < 32'(MARGIN));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_unstable <= 1'b0;
    end else if (result_ld_c) begin
      o_unstable <= unstable_c;
    end
  end
`else
  // MARGIN only matters when the stability comparator is built
  if (MARGIN != 0) begin : g_margin_off
  end
`endif

endmodule
